// File: rtl/tiny_pkg.sv
// tiny_pkg: shared widths, memory sizes and loader state encoding
package tiny_pkg;
    localparam int DATAPATH_W = 8;
    localparam int INST_W = 8;
    localparam int IMEM_SZ = 16;
    localparam int DMEM_SZ = 15;
    localparam int ADDR_W = 4;
    typedef enum logic [1:0] {IDLE, HDR, DATA, ERR} ld_state_t;
endpackage

// File: rtl/pin_sync.sv
// pin_sync: two-flop synchronizer for asynchronous pins, cleared by reset
module pin_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] m;
    always_ff @(posedge clk) begin
        if (!rst_n) {q, m} <= '0;
        else {q, m} <= {m, d};
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: pin-level byte loader writing header-addressed bytes into imem/dmem
module prog_loader
    import tiny_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_mode,
    input  logic                  ld_strobe,
    input  logic [DATAPATH_W-1:0] ld_data,
    output logic                  wr_en,
    output logic                  wr_sel,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATAPATH_W-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  cpu_restart,
    output logic                  ld_err,
    output logic [4:0]            ld_count
);
    ld_state_t state, state_d;
    logic mode_s, stb_s, stb_q, stb_edge, bad_hdr;
    logic [DATAPATH_W-1:0] data_s, wr_data_d;
    logic [ADDR_W-1:0] addr, addr_d, wr_addr_d;
    logic wr_en_d, wr_sel_d, hold_d, restart_d, err_d;
    logic [4:0] cnt_d;
    pin_sync #(.W(1)) u_mode (.clk(clk), .rst_n(rst_n), .d(ld_mode), .q(mode_s));
    pin_sync #(.W(1)) u_stb (.clk(clk), .rst_n(rst_n), .d(ld_strobe), .q(stb_s));
    pin_sync #(.W(DATAPATH_W)) u_data (.clk(clk), .rst_n(rst_n), .d(ld_data), .q(data_s));
    assign stb_edge = stb_s & ~stb_q;
    assign bad_hdr = |data_s[6:4];
    always_comb begin
        state_d = state;
        addr_d = addr;
        wr_en_d = 1'b0;
        wr_sel_d = wr_sel;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        restart_d = 1'b0;
        err_d = ld_err;
        cnt_d = ld_count;
        if (state == IDLE) begin
            if (mode_s) begin
                state_d = HDR;
                err_d = 1'b0;
                cnt_d = '0;
            end
        end else if (!mode_s) begin
            state_d = IDLE;
            restart_d = state == DATA;
        end else if (stb_edge && state == HDR) begin
            wr_sel_d = data_s[7];
            addr_d = data_s[ADDR_W-1:0];
            state_d = bad_hdr ? ERR : DATA;
            err_d = bad_hdr;
        end else if (stb_edge && state == DATA) begin
            // dmem has no entry 15: drop the byte but still wrap the address
            addr_d = addr + 1'b1;
            if (wr_sel && addr == ADDR_W'(DMEM_SZ)) begin
                err_d = 1'b1;
            end else begin
                wr_en_d = 1'b1;
                wr_addr_d = addr;
                wr_data_d = data_s;
                cnt_d = ld_count + 5'(ld_count != 5'd31);
            end
        end
        hold_d = state_d != IDLE || restart_d;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            stb_q <= 1'b0;
            addr <= '0;
            wr_en <= 1'b0;
            wr_sel <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            cpu_hold <= 1'b0;
            cpu_restart <= 1'b0;
            ld_err <= 1'b0;
            ld_count <= '0;
        end else begin
            state <= state_d;
            stb_q <= stb_s;
            addr <= addr_d;
            wr_en <= wr_en_d;
            wr_sel <= wr_sel_d;
            wr_addr <= wr_addr_d;
            wr_data <= wr_data_d;
            cpu_hold <= hold_d;
            cpu_restart <= restart_d;
            ld_err <= err_d;
            ld_count <= cnt_d;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized sessions checked against a session-level loader model
module tb_prog_loader;
    import tiny_pkg::*;
    logic clk = 0, rst_n = 0, ld_mode = 0, ld_strobe = 0;
    logic [7:0] ld_data = 0;
    logic wr_en, wr_sel, cpu_hold, cpu_restart, ld_err;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] ld_count;
    int total = 0, bad = 0, restarts = 0;
    logic rs_prev = 0;
    logic [12:0] got_q[$], exp_q[$];
    logic [7:0] bq[$];
    always #5 clk = ~clk;
    prog_loader dut (
        .clk(clk), .rst_n(rst_n), .ld_mode(ld_mode), .ld_strobe(ld_strobe), .ld_data(ld_data),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .cpu_restart(cpu_restart), .ld_err(ld_err), .ld_count(ld_count)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (wr_en) got_q.push_back({wr_sel, wr_addr, wr_data});
        if (cpu_restart) begin
            restarts++;
            chk("hold_in_restart", cpu_hold, 1);
        end
        if (rs_prev) chk("hold_after_restart", cpu_hold, 0);
        rs_prev = cpu_restart;
    end
    task automatic send_byte(input logic [7:0] b, input logic lat);
        ld_data = b;
        repeat (4) @(negedge clk);
        ld_strobe = 1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (lat) chk("latency", wr_en, i == 3);
        end
        ld_strobe = 0;
        repeat (4) @(negedge clk);
    endtask
    task automatic run_session(input logic send_hdr, input logic [7:0] hdr, input logic coinc, input logic lat);
        logic sel, err, in_data;
        logic [3:0] a;
        int cnt, r0;
        r0 = restarts;
        got_q.delete();
        exp_q.delete();
        ld_mode = 1;
        repeat (6) @(negedge clk);
        chk("hold_session", cpu_hold, 1);
        chk("err_clear", ld_err, 0);
        chk("cnt_clear", ld_count, 0);
        sel = hdr[7];
        a = hdr[3:0];
        err = 0;
        cnt = 0;
        in_data = 0;
        if (send_hdr) begin
            err = |hdr[6:4];
            send_byte(hdr, 0);
            chk("hdr_err", ld_err, err);
            in_data = !err;
            if (!err) foreach (bq[i]) begin
                if (sel && a == 4'd15) begin
                    err = 1;
                    a = 0;
                end else begin
                    exp_q.push_back({sel, a, bq[i]});
                    a++;
                    if (cnt < 31) cnt++;
                end
            end
            foreach (bq[i]) send_byte(bq[i], lat && i == 0);
        end
        if (coinc) begin
            ld_data = 8'($urandom);
            repeat (4) @(negedge clk);
            ld_strobe = 1;
        end
        ld_mode = 0;
        repeat (8) @(negedge clk);
        ld_strobe = 0;
        repeat (2) @(negedge clk);
        chk("restart", restarts - r0, in_data);
        chk("nwrites", got_q.size(), exp_q.size());
        foreach (exp_q[i]) if (i < got_q.size()) chk("write", got_q[i], exp_q[i]);
        chk("err_end", ld_err, err);
        chk("cnt_end", ld_count, cnt);
        chk("hold_end", cpu_hold, 0);
    endtask
    initial begin
        int r0;
        logic [7:0] hdr;
        repeat (3) @(negedge clk);
        chk("rst_outs", {wr_en, wr_sel, wr_addr, wr_data, cpu_hold, cpu_restart, ld_err, ld_count}, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        bq = '{8'h44, 8'h0F, 8'h1E};
        run_session(1, 8'h02, 0, 1);
        bq = '{8'hAA, 8'hBB, 8'hCC};
        run_session(1, 8'h8E, 0, 0);
        bq = '{8'h33, 8'h44};
        run_session(1, 8'h12, 0, 0);
        bq = '{8'h77};
        run_session(1, 8'h05, 1, 0);
        bq.delete();
        run_session(0, 8'h00, 1, 0);
        run_session(1, 8'h70, 1, 0);
        // reset in the middle of a dmem session, mode left high
        r0 = restarts;
        got_q.delete();
        ld_mode = 1;
        repeat (6) @(negedge clk);
        send_byte(8'h81, 0);
        send_byte(8'h5A, 0);
        chk("pre_rst_writes", got_q.size(), 1);
        rst_n = 0;
        @(negedge clk);
        chk("mid_rst_outs", {wr_en, wr_sel, wr_addr, wr_data, cpu_hold, cpu_restart, ld_err, ld_count}, 0);
        rst_n = 1;
        repeat (4) @(negedge clk);
        chk("no_restart_rst", restarts - r0, 0);
        chk("no_write_rst", got_q.size(), 1);
        bq = '{8'h11, 8'h22};
        run_session(1, 8'h03, 0, 0);
        bq.delete();
        for (int i = 0; i < 34; i++) bq.push_back(8'($urandom));
        run_session(1, 8'h00, 0, 0);
        for (int s = 0; s < 15; s++) begin
            hdr = 8'($urandom);
            if ($urandom_range(3) != 0) hdr[6:4] = 3'b0;
            bq.delete();
            for (int i = 0; i < int'($urandom_range(10)); i++) bq.push_back(8'($urandom));
            run_session($urandom_range(7) != 0, hdr, 1'($urandom_range(1)), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
